// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder: 16-bit frames (RW, ADDR[6:0], DATA) read/write a bank of 8-bit registers.
// SPI pins are oversampled on clk, so the whole block lives in a single clock domain.
module spi_reg_responder #(
  parameter int          NREG     = 8,
  parameter logic [7:0]  ID_VALUE = 8'h5A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [7:0]        status_in,
  output logic [NREG*8-1:0] reg_out,
  output logic              wr_strobe,
  output logic [6:0]        wr_addr,
  output logic              frame_err
);

  typedef enum logic [2:0] {WAIT_SS, IDLE, HEADER, DATA, DONE} state_t;

  localparam logic [7:0] NREG_W = 8'(NREG);

  state_t     state;
  logic [2:0] sclk_sr;
  logic [2:0] ss_sr;
  logic [1:0] mosi_sr;
  logic [1:0] settle;
  logic [4:0] bitcnt;
  logic [6:0] cmd;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] txbyte;
  logic [7:0] rxbyte;
  logic       wr_pending;

  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic       ss_n_sync, mosi_sync;
  logic [7:0] hdr_byte;
  logic [6:0] hdr_addr;
  logic [7:0] rd_value;

  // ss_n resets to "deselected" so the pad driver stays off while the block is in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr <= 3'b000;
      ss_sr   <= 3'b111;
      mosi_sr <= 2'b00;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi_sclk};
      ss_sr   <= {ss_sr[1:0], spi_ss_n};
      mosi_sr <= {mosi_sr[0], spi_mosi};
    end
  end

  assign ss_n_sync   = ss_sr[1];
  assign mosi_sync   = mosi_sr[1];
  assign sclk_rise   = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall   = ~sclk_sr[1] & sclk_sr[2];
  assign ss_rise     = ss_sr[1] & ~ss_sr[2];
  assign ss_fall     = ~ss_sr[1] & ss_sr[2];
  assign spi_miso_oe = ~ss_n_sync;

  assign hdr_byte = {cmd, mosi_sync};
  assign hdr_addr = hdr_byte[6:0];

  always_comb begin
    rd_value = 8'h00;
    if (hdr_addr == 7'h7E) begin
      rd_value = status_in;
    end else if (hdr_addr == 7'h7F) begin
      rd_value = ID_VALUE;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (hdr_addr == 7'(k)) rd_value = reg_out[8*k +: 8];
      end
    end
  end

  // settle lets the reset values flush out of the synchronizers before WAIT_SS trusts ss_n
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_SS;
      settle     <= 2'd0;
      bitcnt     <= 5'd0;
      cmd        <= 7'd0;
      rw         <= 1'b0;
      addr       <= 7'd0;
      txbyte     <= 8'd0;
      rxbyte     <= 8'd0;
      wr_pending <= 1'b0;
      reg_out    <= '0;
      spi_miso   <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= 7'd0;
      frame_err  <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;

      if (wr_pending) begin
        for (int k = 0; k < NREG; k++) begin
          if (addr == 7'(k)) reg_out[8*k +: 8] <= rxbyte;
        end
        wr_strobe  <= 1'b1;
        wr_addr    <= addr;
        wr_pending <= 1'b0;
      end

      case (state)
        WAIT_SS: begin
          spi_miso <= 1'b0;
          if (settle != 2'd3) begin
            settle <= settle + 2'd1;
          end else if (ss_n_sync) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          spi_miso <= 1'b0;
          if (ss_fall) begin
            bitcnt <= 5'd0;
            state  <= HEADER;
          end
        end

        HEADER: begin
          if (ss_rise) begin
            frame_err <= (bitcnt != 5'd0);
            spi_miso  <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise && bitcnt < 5'd8) begin
            cmd    <= hdr_byte[6:0];
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd7) begin
              rw     <= hdr_byte[7];
              addr   <= hdr_addr;
              txbyte <= rd_value;
            end
          end else if (sclk_fall && bitcnt == 5'd8) begin
            spi_miso <= txbyte[7];
            state    <= DATA;
          end
        end

        DATA: begin
          if (ss_rise) begin
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            rxbyte <= {rxbyte[6:0], mosi_sync};
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd15) begin
              wr_pending <= ~rw && ({1'b0, addr} < NREG_W);
              state      <= DONE;
            end
          end else if (sclk_fall) begin
            txbyte   <= {txbyte[6:0], 1'b0};
            spi_miso <= txbyte[6];
          end
        end

        DONE: begin
          spi_miso <= 1'b0;
          if (ss_rise) state <= IDLE;
        end

        default: state <= WAIT_SS;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: a table of whole frames scored through an expectation queue,
// followed by hand-written abort, over-long frame and mid-frame reset sequences.
module tb_spi_reg_responder;

  localparam int NREG = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              spi_sclk;
  logic              spi_ss_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [7:0]        status_in;
  logic [NREG*8-1:0] reg_out;
  logic              wr_strobe;
  logic [6:0]        wr_addr;
  logic              frame_err;

  spi_reg_responder #(.NREG(NREG), .ID_VALUE(8'h5A)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sclk    (spi_sclk),
    .spi_ss_n    (spi_ss_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .status_in   (status_in),
    .reg_out     (reg_out),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .frame_err   (frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  status;
    logic        is_read;
    logic [7:0]  exp_miso;
    int          exp_strobes;
  } vec_t;

  typedef struct {
    logic        is_read;
    logic [7:0]  miso;
    int          strobes;
  } exp_t;

  int          checks = 0;
  int          passes = 0;
  int          strobe_cnt = 0;
  int          err_cnt = 0;
  int          strobe0, err0;
  logic [7:0]  model_regs [NREG];
  logic [6:0]  model_last_addr;
  logic [31:0] rx;
  exp_t        exp_q [$];
  vec_t        vecs [12];

  // Pulse counters: a stretched or repeated pulse shows up as an extra count
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt = strobe_cnt + 1;
    if (frame_err) err_cnt = err_cnt + 1;
  end

  function automatic logic [NREG*8-1:0] model_packed();
    logic [NREG*8-1:0] p;
    for (int k = 0; k < NREG; k++) p[8*k +: 8] = model_regs[k];
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act === exp) passes = passes + 1;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One sclk period is 8 clk; miso is sampled 2 clk after each rise
  task automatic shift_bits(input logic [31:0] bits, input int n, output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (2) @(negedge clk);
      r = {r[30:0], spi_miso};
      repeat (2) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [31:0] bits, input int n, output logic [31:0] r);
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(bits, n, r);
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    e.is_read = v.is_read;
    e.miso    = v.exp_miso;
    e.strobes = v.exp_strobes;
    if (v.exp_strobes != 0) begin
      model_regs[v.frame[10:8]] = v.frame[7:0];
      model_last_addr = v.frame[14:8];
    end
    exp_q.push_back(e);
    status_in = v.status;
    strobe0 = strobe_cnt;
    err0 = err_cnt;
    run_frame({16'h0, v.frame}, 16, rx);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks = checks + 1;
      $display("[TB] FAIL scoreboard_empty vec %0d: got no expectation, expected one", idx);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("v%0d header_miso", idx), {56'h0, rx[15:8]}, 64'h0);
    if (e.is_read) check($sformatf("v%0d read_data", idx), {56'h0, rx[7:0]}, {56'h0, e.miso});
    check($sformatf("v%0d strobes", idx), 64'(strobe_cnt - strobe0), 64'(e.strobes));
    check($sformatf("v%0d wr_addr", idx), {57'h0, wr_addr}, {57'h0, model_last_addr});
    check($sformatf("v%0d reg_out", idx), reg_out, model_packed());
    check($sformatf("v%0d frame_err", idx), 64'(err_cnt - err0), 64'h0);
  endtask

  initial begin
    for (int k = 0; k < NREG; k++) model_regs[k] = 8'h00;
    model_last_addr = 7'h00;

    vecs[0]  = '{16'h03A5, 8'h00, 1'b0, 8'h00, 1};
    vecs[1]  = '{16'h8300, 8'h00, 1'b1, 8'hA5, 0};
    vecs[2]  = '{16'hFF00, 8'h00, 1'b1, 8'h5A, 0};
    vecs[3]  = '{16'hFE00, 8'h3C, 1'b1, 8'h3C, 0};
    vecs[4]  = '{16'h7F11, 8'h00, 1'b0, 8'h00, 0};
    vecs[5]  = '{16'hA000, 8'h00, 1'b1, 8'h00, 0};
    vecs[6]  = '{16'h2077, 8'h00, 1'b0, 8'h00, 0};
    vecs[7]  = '{16'h0011, 8'h00, 1'b0, 8'h00, 1};
    vecs[8]  = '{16'h0722, 8'h00, 1'b0, 8'h00, 1};
    vecs[9]  = '{16'h8700, 8'h00, 1'b1, 8'h22, 0};
    vecs[10] = '{16'h0899, 8'h00, 1'b0, 8'h00, 0};
    vecs[11] = '{16'hFE00, 8'hC3, 1'b1, 8'hC3, 0};

    reset = 1'b1;
    spi_sclk = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    status_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst reg_out", reg_out, 64'h0);
    check("rst miso", {63'h0, spi_miso}, 64'h0);
    check("rst oe", {63'h0, spi_miso_oe}, 64'h0);
    check("rst wr_strobe", {63'h0, wr_strobe}, 64'h0);
    check("rst wr_addr", {57'h0, wr_addr}, 64'h0);
    check("rst frame_err", {63'h0, frame_err}, 64'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Abort after 11 bits of a write, then the same frame in full
    strobe0 = strobe_cnt;
    err0 = err_cnt;
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    check("oe during frame", {63'h0, spi_miso_oe}, 64'h1);
    shift_bits(32'h05BB >> 5, 11, rx);
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort frame_err", 64'(err_cnt - err0), 64'h1);
    check("abort strobes", 64'(strobe_cnt - strobe0), 64'h0);
    check("abort reg_out", reg_out, model_packed());
    strobe0 = strobe_cnt;
    run_frame(32'h05BB, 16, rx);
    model_regs[5] = 8'hBB;
    check("post-abort strobes", 64'(strobe_cnt - strobe0), 64'h1);
    check("post-abort wr_addr", {57'h0, wr_addr}, 64'h5);
    check("post-abort reg_out", reg_out, model_packed());

    // 20 sclk pulses in one frame: the extra four edges land in DONE
    strobe0 = strobe_cnt;
    err0 = err_cnt;
    run_frame(32'h0466A, 20, rx);
    model_regs[4] = 8'h66;
    check("long strobes", 64'(strobe_cnt - strobe0), 64'h1);
    check("long wr_addr", {57'h0, wr_addr}, 64'h4);
    check("long reg_out", reg_out, model_packed());
    check("long frame_err", 64'(err_cnt - err0), 64'h0);

    // Reset at bit 12 of a write with ss_n held low, release and finish the frame
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(32'h0199 >> 4, 12, rx);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst reg_out", reg_out, 64'h0);
    check("midrst oe", {63'h0, spi_miso_oe}, 64'h0);
    reset = 1'b0;
    for (int k = 0; k < NREG; k++) model_regs[k] = 8'h00;
    model_last_addr = 7'h00;
    strobe0 = strobe_cnt;
    err0 = err_cnt;
    shift_bits(32'h9, 4, rx);
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst strobes", 64'(strobe_cnt - strobe0), 64'h0);
    check("midrst frame_err", 64'(err_cnt - err0), 64'h0);
    check("midrst reg_after", reg_out, model_packed());
    strobe0 = strobe_cnt;
    run_frame(32'h0144, 16, rx);
    model_regs[1] = 8'h44;
    check("recover strobes", 64'(strobe_cnt - strobe0), 64'h1);
    check("recover wr_addr", {57'h0, wr_addr}, 64'h1);
    check("recover reg_out", reg_out, model_packed());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
